// File: rtl/bnn_conv_pkg.sv
// Shared definitions for the BNN conv path: controller state encoding and the
// expected window count of one frame for a given geometry and stride.
package bnn_conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Rows/columns beyond the last stride-reachable position yield no window.
  function automatic int exp_windows(input int k, input int len, input int height,
                                     input int stride);
    return ((height - k) / stride + 1) * ((len - k) / stride + 1);
  endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Pixel row/column counter with column wrap and per-axis stride phase.
// Updates one cycle after inc; clr has priority over inc and never stalls.
module conv_pos_counter #(
  parameter int K      = 3,
  parameter int LEN    = 9,
  parameter int STRIDE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] ph_col,
  output logic [CNT_W-1:0] ph_row,
  output logic             col_last
);

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] EDGE     = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(STRIDE - 1);

  logic [CNT_W-1:0] ph_col_step;
  logic [CNT_W-1:0] ph_row_step;

  assign col_last    = (col == LAST_COL);
  assign ph_col_step = (ph_col == PH_LAST) ? '0 : ph_col + 1'b1;
  assign ph_row_step = (ph_row == PH_LAST) ? '0 : ph_row + 1'b1;

  // Phases stay at 0 until the kernel fits, so the first aligned window sits at K-1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col    <= '0;
      row    <= '0;
      ph_col <= '0;
      ph_row <= '0;
    end else if (inc) begin
      if (col_last) begin
        col    <= '0;
        row    <= row + 1'b1;
        ph_col <= '0;
        ph_row <= (row >= EDGE) ? ph_row_step : '0;
      end else begin
        col    <= col + 1'b1;
        ph_col <= (col >= EDGE) ? ph_col_step : '0;
      end
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for the K x K sliding-window line buffer: gates pixel input and
// flags stride-aligned windows one cycle after the accept; m_ready low stalls input.
module conv_window_ctrl
  import bnn_conv_pkg::*;
#(
  parameter int K      = 3,
  parameter int LEN    = 9,
  parameter int HEIGHT = 9,
  parameter int STRIDE = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             m_ready,
  output logic             lb_clr,
  output logic             lb_ivalid,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic [CNT_W-1:0] win_cnt
);

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] EDGE     = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] EXP_WIN  = CNT_W'(exp_windows(K, LEN, HEIGHT, STRIDE));

  state_t           state, state_nxt;
  logic             accept;
  logic             col_last;
  logic             row_aligned;
  logic             win_hit;
  logic [CNT_W-1:0] pix_col, pix_row, ph_col, ph_row;
  logic [CNT_W-1:0] oc_row, oc_col;

  conv_pos_counter #(
    .K      (K),
    .LEN    (LEN),
    .STRIDE (STRIDE),
    .CNT_W  (CNT_W)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .clr      (lb_clr),
    .inc      (accept),
    .col      (pix_col),
    .row      (pix_row),
    .ph_col   (ph_col),
    .ph_row   (ph_row),
    .col_last (col_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // The line buffer shifts unconditionally, so downstream backpressure gates input.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    s_ready   = 1'b0;
    lb_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_STREAM;
          lb_clr    = !rst;
        end
      end
      ST_STREAM: begin
        busy    = 1'b1;
        s_ready = m_ready && !rst;
        if (s_valid && s_ready && col_last && (pix_row == LAST_ROW))
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept      = s_valid && s_ready;
  assign lb_ivalid   = accept;
  assign row_aligned = (pix_row >= EDGE) && (ph_row == '0);
  assign win_hit     = accept && row_aligned && (pix_col >= EDGE) && (ph_col == '0);

  // oc_row/oc_col are the coordinates the next aligned window will carry.
  always_ff @(posedge clk) begin
    if (rst || lb_clr) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      win_cnt   <= '0;
      oc_row    <= '0;
      oc_col    <= '0;
    end else begin
      win_valid <= win_hit;
      if (win_hit) begin
        win_row <= oc_row;
        win_col <= oc_col;
        win_cnt <= win_cnt + 1'b1;
        oc_col  <= oc_col + 1'b1;
      end
      if (accept && col_last) begin
        oc_col <= '0;
        if (row_aligned) oc_row <= oc_row + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == ST_DONE) assert (win_cnt == EXP_WIN);
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: stride-1 and stride-2 instances share stimulus;
// expected windows are queued at each accept and matched as they appear.
module tb_conv_window_ctrl;
  import bnn_conv_pkg::*;

  localparam int K = 3, LEN = 9, HEIGHT = 9, NPIX = LEN * HEIGHT;
  localparam int EXP1 = exp_windows(K, LEN, HEIGHT, 1);
  localparam int EXP2 = exp_windows(K, LEN, HEIGHT, 2);

  typedef struct packed { int cyc; logic [7:0] row; logic [7:0] col; } win_t;

  logic clk = 1'b0;
  logic rst, start, s_valid, m_ready;
  logic busy1, done1, s_ready1, lb_clr1, lb_ivalid1, win_valid1;
  logic busy2, done2, s_ready2, lb_clr2, lb_ivalid2, win_valid2;
  logic [7:0] win_row1, win_col1, win_cnt1, win_row2, win_col2, win_cnt2;

  int   checks = 0, errors = 0, cyc_ctr = 0, seen1 = 0, seen2 = 0, n_ivalid = 0;
  win_t q1[$], q2[$];
  win_t e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  conv_window_ctrl #(.K(K), .LEN(LEN), .HEIGHT(HEIGHT), .STRIDE(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .s_valid(s_valid), .s_ready(s_ready1), .m_ready(m_ready), .lb_clr(lb_clr1),
    .lb_ivalid(lb_ivalid1), .win_valid(win_valid1), .win_row(win_row1),
    .win_col(win_col1), .win_cnt(win_cnt1));

  conv_window_ctrl #(.K(K), .LEN(LEN), .HEIGHT(HEIGHT), .STRIDE(2), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .busy(busy2), .done(done2),
    .s_valid(s_valid), .s_ready(s_ready2), .m_ready(m_ready), .lb_clr(lb_clr2),
    .lb_ivalid(lb_ivalid2), .win_valid(win_valid2), .win_row(win_row2),
    .win_col(win_col2), .win_cnt(win_cnt2));

  // Window monitor: every pulse must match the oldest queued window and cycle.
  always @(negedge clk) begin
    if (lb_clr1) seen1 = 0;
    if (lb_clr2) seen2 = 0;
    if (win_valid1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL win1_unexpected got r%0d c%0d required no window", win_row1, win_col1);
      end else begin
        e1 = q1.pop_front();
        seen1++;
        if (win_row1 !== e1.row || win_col1 !== e1.col || cyc_ctr !== e1.cyc ||
            win_cnt1 !== 8'(seen1)) begin
          errors++;
          $display("FAIL win1 got r%0d c%0d cyc%0d cnt%0d required r%0d c%0d cyc%0d cnt%0d",
                   win_row1, win_col1, cyc_ctr, win_cnt1, e1.row, e1.col, e1.cyc, seen1);
        end
      end
    end
    if (win_valid2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL win2_unexpected got r%0d c%0d required no window", win_row2, win_col2);
      end else begin
        e2 = q2.pop_front();
        seen2++;
        if (win_row2 !== e2.row || win_col2 !== e2.col || cyc_ctr !== e2.cyc ||
            win_cnt2 !== 8'(seen2)) begin
          errors++;
          $display("FAIL win2 got r%0d c%0d cyc%0d cnt%0d required r%0d c%0d cyc%0d cnt%0d",
                   win_row2, win_col2, cyc_ctr, win_cnt2, e2.row, e2.col, e2.cyc, seen2);
        end
      end
    end
  end

  // Drives one frame; alt = valid every other cycle, stall_at = pixel index before
  // which m_ready drops for 5 cycles, start_mid/abort_at = pixel index for a stray
  // start or a reset pulse (-1 disables).
  task automatic run_frame(input bit alt, input int stall_at, input int start_mid,
                           input int abort_at);
    int pix, cyc, stall_left, r, c;
    bit exp_acc, aborted;
    pix = 0; cyc = 0; stall_left = 5; aborted = 0; n_ivalid = 0;
    @(posedge clk); #1;
    start = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (lb_clr1 !== 1'b1 || lb_clr2 !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL start_clr got clr=%b/%b busy=%b required 1/1/0", lb_clr1, lb_clr2, busy1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    while (pix < NPIX) begin
      if (cyc > 600) begin
        checks++; errors++;
        $display("FAIL frame_timeout got %0d pixels required %0d", pix, NPIX);
        break;
      end
      s_valid = alt ? (cyc % 2 == 0) : 1'b1;
      m_ready = 1'b1;
      if (pix == stall_at && stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end
      start   = (pix == start_mid);
      rst     = (pix == abort_at);
      exp_acc = s_valid && m_ready && !rst;
      @(negedge clk);
      checks++;
      if (s_ready1 !== (m_ready && !rst) || lb_ivalid1 !== exp_acc ||
          lb_ivalid2 !== exp_acc || lb_clr1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
        errors++;
        $display("FAIL stream pix%0d got rdy=%b iv=%b/%b clr=%b busy=%b done=%b required rdy=%b iv=%b clr=0 busy=1 done=0",
                 pix, s_ready1, lb_ivalid1, lb_ivalid2, lb_clr1, busy1, done1,
                 m_ready && !rst, exp_acc);
      end
      if (lb_ivalid1) n_ivalid++;
      if (exp_acc) begin
        r = pix / LEN; c = pix % LEN;
        if (r >= K - 1 && c >= K - 1) begin
          q1.push_back('{cyc: cyc_ctr + 1, row: 8'(r - K + 1), col: 8'(c - K + 1)});
          if ((r - K + 1) % 2 == 0 && (c - K + 1) % 2 == 0)
            q2.push_back('{cyc: cyc_ctr + 1, row: 8'((r - K + 1) / 2), col: 8'((c - K + 1) / 2)});
        end
        pix++;
      end
      cyc++;
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0; aborted = 1'b1;
        break;
      end
    end
    start = 1'b0; s_valid = 1'b0;
    if (aborted) begin
      @(negedge clk);
      checks++;
      if ({busy1, done1, s_ready1, lb_clr1, lb_ivalid1, win_valid1} !== 6'b0 ||
          win_row1 !== 8'd0 || win_col1 !== 8'd0 || win_cnt1 !== 8'd0 ||
          busy2 !== 1'b0 || win_cnt2 !== 8'd0) begin
        errors++;
        $display("FAIL abort_state got busy=%b done=%b rdy=%b clr=%b iv=%b wv=%b r%0d c%0d cnt%0d/%0d required all 0",
                 busy1, done1, s_ready1, lb_clr1, lb_ivalid1, win_valid1,
                 win_row1, win_col1, win_cnt1, win_cnt2);
      end
      repeat (4) begin
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0 || done2 !== 1'b0 || busy1 !== 1'b0) begin
          errors++;
          $display("FAIL abort_no_done got done=%b/%b busy=%b required 0/0/0", done1, done2, busy1);
        end
      end
    end else begin
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || done2 !== 1'b1 || busy1 !== 1'b1 || s_ready1 !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse got done=%b/%b busy=%b rdy=%b required 1/1/1/0",
                 done1, done2, busy1, s_ready1);
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
        errors++;
        $display("FAIL idle_after got done=%b busy=%b/%b required 0/0/0", done1, busy1, busy2);
      end
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL pending_windows got %0d/%0d left required 0/0", q1.size(), q2.size());
    end
  endtask

  task automatic check_totals(input string name);
    repeat (3) @(negedge clk);
    checks++;
    if (win_cnt1 !== 8'(EXP1) || seen1 != EXP1 || win_cnt2 !== 8'(EXP2) ||
        seen2 != EXP2 || n_ivalid != NPIX) begin
      errors++;
      $display("FAIL %s_totals got cnt=%0d/%0d seen=%0d/%0d iv=%0d required %0d/%0d %0d/%0d %0d",
               name, win_cnt1, win_cnt2, seen1, seen2, n_ivalid, EXP1, EXP2, EXP1, EXP2, NPIX);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy1, done1, s_ready1, lb_clr1, lb_ivalid1, win_valid1} !== 6'b0 ||
        win_row1 !== 8'd0 || win_col1 !== 8'd0 || win_cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b rdy=%b clr=%b iv=%b wv=%b r%0d c%0d cnt%0d required all 0",
               busy1, done1, s_ready1, lb_clr1, lb_ivalid1, win_valid1, win_row1, win_col1, win_cnt1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || s_ready1 !== 1'b0 || lb_ivalid1 !== 1'b0 || win_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_accept got busy=%b rdy=%b iv=%b wv2=%b required 0", busy1, s_ready1,
               lb_ivalid1, win_valid2);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_full_frame;
    run_frame(1'b0, -1, -1, -1);
    check_totals("full");
  endtask

  task automatic test_alt_valid;
    run_frame(1'b1, -1, -1, -1);
    check_totals("alt");
  endtask

  task automatic test_stride2;
    run_frame(1'b0, -1, -1, -1);
    repeat (2) @(negedge clk);
    checks++;
    if (win_cnt2 !== 8'd16 || win_row2 !== 8'd3 || win_col2 !== 8'd3) begin
      errors++;
      $display("FAIL stride2_last got cnt%0d r%0d c%0d required cnt16 r3 c3", win_cnt2, win_row2, win_col2);
    end
  endtask

  task automatic test_stall;
    run_frame(1'b0, 13, -1, -1);
    check_totals("stall");
  endtask

  task automatic test_start_ignored;
    run_frame(1'b0, -1, 30, -1);
    check_totals("start_mid");
  endtask

  task automatic test_abort;
    run_frame(1'b0, -1, -1, 41);
    run_frame(1'b0, -1, -1, -1);
    check_totals("after_abort");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    test_reset;
    test_full_frame;
    test_alt_valid;
    test_stride2;
    test_stall;
    test_start_ignored;
    test_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
